inner_fn_stream_ctrl: RTL



---
 rtl/inner_fn_pkg.sv | 18 +
 rtl/inner_fn_vld_tracker.sv | 25 ++
 rtl/inner_fn_stream_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/inner_fn_pkg.sv
// Shared types and constants for the inner-function stream controller and its bench.
// f(x) = 0.5*x + x^2*cos((x-128)/128); FP_F128 is f(128.0) = 16448.0.
package inner_fn_pkg;

    localparam int unsigned PIPE_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_128  = 32'h4300_0000;
    localparam logic [31:0] FP_F128 = 32'h4680_8000;

endpackage

// File: rtl/inner_fn_vld_tracker.sv
// One valid bit per pipeline stage; shifts only on enabled edges so it stays
// aligned with the clock-enabled datapath.
module inner_fn_vld_tracker #(
    parameter int unsigned DEPTH = 15
) (
    input  logic clk,
    input  logic aclr,
    input  logic advance,
    input  logic insert,
    output logic tail
);

    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            vld <= '0;
        end else if (advance) begin
            vld <= {vld[DEPTH-2:0], insert};
        end
    end

    assign tail = vld[DEPTH-1];

endmodule

// File: rtl/inner_fn_stream_ctrl.sv
// Job sequencer for the pipelined inner-function datapath: issues N operands,
// tracks live slots and stalls the whole pipeline when the consumer back-pressures.
module inner_fn_stream_ctrl #(
    parameter int unsigned PIPE_LATENCY = inner_fn_pkg::PIPE_LATENCY,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             start,
    input  logic [CNT_W-1:0] n_elems,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             pipe_en,
    output logic [31:0]      pipe_dataa,
    input  logic [31:0]      pipe_result
);

    import inner_fn_pkg::*;

    state_t           state;
    logic [CNT_W-1:0] n_len;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] retired;
    logic             advance;
    logic             accept;
    logic             retire;
    logic             tail;

    // The pipeline only freezes when a finished result cannot leave.
    assign advance    = ~(tail & ~out_ready);
    assign pipe_en    = advance;
    assign in_ready   = (state == RUN) && advance && (issued < n_len);
    assign accept     = in_valid & in_ready;
    assign retire     = tail & out_ready;

    assign pipe_dataa = in_data;
    assign out_valid  = tail;
    assign out_data   = pipe_result;
    assign out_last   = tail && (retired == n_len - CNT_W'(1));

    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

    inner_fn_vld_tracker #(
        .DEPTH(PIPE_LATENCY)
    ) u_vld (
        .clk    (clk),
        .aclr   (aclr),
        .advance(advance),
        .insert (accept),
        .tail   (tail)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state   <= IDLE;
            n_len   <= '0;
            issued  <= '0;
            retired <= '0;
        end else begin
            if (accept) issued  <= issued + CNT_W'(1);
            if (retire) retired <= retired + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        n_len   <= n_elems;
                        issued  <= '0;
                        retired <= '0;
                        state   <= (n_elems != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept && (issued + CNT_W'(1) == n_len)) state <= DRAIN;
                end
                DRAIN: begin
                    if (retire && (retired + CNT_W'(1) == n_len)) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
